// File: rtl/tft_timing_ctrl.sv
// tft_timing_ctrl: sync/DE timing generator and pixel sink for an RGB565 TFT panel.
// Coordinates are requested one clock before display. The upstream generator
// registers pix_data, so the returned colour lines up with tft_de.
module tft_timing_ctrl #(
    parameter int unsigned H_SYNC  = 41,
    parameter int unsigned H_BACK  = 2,
    parameter int unsigned H_VALID = 480,
    parameter int unsigned H_FRONT = 2,
    parameter int unsigned V_SYNC  = 10,
    parameter int unsigned V_BACK  = 2,
    parameter int unsigned V_VALID = 272,
    parameter int unsigned V_FRONT = 2
) (
    input  logic        tft_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] rgb_tft,
    output logic        hsync,
    output logic        vsync,
    output logic        tft_de,
    output logic        tft_bl,
    output logic        frame_start
);

    localparam logic [9:0] H_TOTAL   = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT);
    localparam logic [9:0] V_TOTAL   = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT);
    localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0] HA        = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] HA_END    = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] REQ_START = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] REQ_END   = 10'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [9:0] VA        = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] VA_END    = 10'(V_SYNC + V_BACK + V_VALID);

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       v_act;
    logic       h_act;
    logic       pix_req;

    // Horizontal pixel counter, wraps at the end of each line.
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            cnt_h <= '0;
        else if (cnt_h == H_TOTAL - 10'd1)
            cnt_h <= '0;
        else
            cnt_h <= cnt_h + 10'd1;
    end

    // Vertical line counter, advances on the last pixel of each line.
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            cnt_v <= '0;
        else if (cnt_h == H_TOTAL - 10'd1) begin
            if (cnt_v == V_TOTAL - 10'd1)
                cnt_v <= '0;
            else
                cnt_v <= cnt_v + 10'd1;
        end
    end

    // Output decode straight from the counters; the request window leads the
    // display window by one clock to cover the generator's register stage.
    always_comb begin
        v_act       = (cnt_v >= VA) && (cnt_v < VA_END);
        h_act       = (cnt_h >= HA) && (cnt_h < HA_END);
        pix_req     = v_act && (cnt_h >= REQ_START) && (cnt_h < REQ_END);
        hsync       = (cnt_h < H_SYNC_W);
        vsync       = (cnt_v < V_SYNC_W);
        tft_de      = v_act && h_act;
        frame_start = (cnt_h == '0) && (cnt_v == '0);
        pix_x       = '1;
        pix_y       = '1;
        if (pix_req) begin
            pix_x = cnt_h - REQ_START;
            pix_y = cnt_v - VA;
        end
        rgb_tft = tft_de ? pix_data : '0;
    end

    assign tft_bl = sys_rst_n;

endmodule

// File: tb/tb_tft_timing_ctrl.sv
// tb_tft_timing_ctrl: directed checks of tft_timing_ctrl on a reduced panel
// geometry so whole frames fit in a short run.
module tb_tft_timing_ctrl;

    localparam int unsigned HS = 5,  HB = 3, HV = 20, HF = 4;
    localparam int unsigned VS = 3,  VB = 2, VV = 8,  VF = 3;
    localparam int unsigned HT = HS + HB + HV + HF;   // 32
    localparam int unsigned VT = VS + VB + VV + VF;   // 16
    localparam int unsigned HA = HS + HB;             // 8
    localparam int unsigned VA = VS + VB;             // 5
    localparam int unsigned FRAME = HT * VT;          // 512
    localparam int unsigned LIMIT = 4 * FRAME;

    logic        tft_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] pix_data = '0;
    logic [9:0]  pix_x, pix_y;
    logic [15:0] rgb_tft;
    logic        hsync, vsync, tft_de, tft_bl, frame_start;

    int unsigned t;
    int unsigned guard;
    int          n_checks = 0;
    int          n_fail = 0;

    tft_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF)
    ) dut (
        .tft_clk(tft_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .rgb_tft(rgb_tft),
        .hsync(hsync), .vsync(vsync), .tft_de(tft_de),
        .tft_bl(tft_bl), .frame_start(frame_start)
    );

    always #5 tft_clk = ~tft_clk;

    // Stub pixel generator: registers {row[5:0], col} from the request.
    always_ff @(posedge tft_clk) pix_data <= {pix_y[5:0], pix_x};

    task automatic step;
        @(negedge tft_clk);
        t++;
        guard++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge tft_clk);
        n_checks++;
        if ({hsync, vsync, tft_de, frame_start, tft_bl} !== 5'b11010) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected 11010", {hsync, vsync, tft_de, frame_start, tft_bl});
        end
        n_checks++;
        if ({pix_x, pix_y} !== 20'hFFFFF) begin
            n_fail++;
            $display("FAIL reset_pix: got x=%h y=%h expected 3ff 3ff", pix_x, pix_y);
        end
        n_checks++;
        if (rgb_tft !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_rgb: got %h expected 0000", rgb_tft);
        end
        sys_rst_n = 1'b1;
        t = 0;
    endtask

    task automatic test_first_de(input string tag);
        int first_req = -1;
        int first_de = -1;
        guard = 0;
        while (guard < LIMIT) begin
            if (first_req < 0 && pix_x == 10'd0 && pix_y == 10'd0) first_req = int'(t);
            if (tft_de === 1'b1) begin
                first_de = int'(t);
                break;
            end
            step();
        end
        n_checks++;
        if (first_de != int'(VA * HT + HA)) begin
            n_fail++;
            $display("FAIL %s_first_de: got cycle %0d expected %0d", tag, first_de, VA * HT + HA);
        end
        n_checks++;
        if (first_req != int'(VA * HT + HA - 1)) begin
            n_fail++;
            $display("FAIL %s_first_req: got cycle %0d expected %0d", tag, first_req, VA * HT + HA - 1);
        end
    endtask

    task automatic test_line;
        int unsigned hi = 0, per = 0, de_hi = 0, de_lo = 0;
        guard = 0;
        while (hsync !== 1'b0 && guard < LIMIT) step();
        while (hsync !== 1'b1 && guard < LIMIT) step();
        while (hsync === 1'b1 && guard < LIMIT) begin hi++; step(); end
        per = hi;
        while (hsync === 1'b0 && guard < LIMIT) begin per++; step(); end
        while (tft_de !== 1'b1 && guard < LIMIT) step();
        while (tft_de === 1'b1 && guard < LIMIT) begin de_hi++; step(); end
        while (tft_de === 1'b0 && guard < LIMIT) begin de_lo++; step(); end
        n_checks++;
        if (guard >= LIMIT) begin
            n_fail++;
            $display("FAIL line_timeout: got %0d cycles expected under %0d", guard, LIMIT);
        end
        n_checks++;
        if (hi != HS) begin n_fail++; $display("FAIL hsync_width: got %0d expected %0d", hi, HS); end
        n_checks++;
        if (per != HT) begin n_fail++; $display("FAIL hsync_period: got %0d expected %0d", per, HT); end
        n_checks++;
        if (de_hi != HV) begin n_fail++; $display("FAIL de_width: got %0d expected %0d", de_hi, HV); end
        n_checks++;
        if (de_lo != HT - HV) begin n_fail++; $display("FAIL de_gap: got %0d expected %0d", de_lo, HT - HV); end
    endtask

    task automatic test_frame;
        int unsigned per = 0, fs_cnt = 0, vs_cnt = 0;
        logic [9:0] last_y = 10'h3FF;
        guard = 0;
        while (frame_start !== 1'b1 && guard < LIMIT) step();
        do begin
            if (frame_start === 1'b1) fs_cnt++;
            if (vsync === 1'b1) vs_cnt++;
            if (pix_y !== 10'h3FF) last_y = pix_y;
            per++;
            step();
        end while (frame_start !== 1'b1 && guard < LIMIT);
        n_checks++;
        if (per != FRAME) begin n_fail++; $display("FAIL frame_period: got %0d expected %0d", per, FRAME); end
        n_checks++;
        if (fs_cnt != 1) begin n_fail++; $display("FAIL frame_start_width: got %0d expected 1", fs_cnt); end
        n_checks++;
        if (vs_cnt != VS * HT) begin n_fail++; $display("FAIL vsync_width: got %0d expected %0d", vs_cnt, VS * HT); end
        n_checks++;
        if (last_y !== 10'(VV - 1)) begin n_fail++; $display("FAIL last_row: got %0d expected %0d", last_y, VV - 1); end
    endtask

    // Cycle-by-cycle check of every output against the position implied by
    // the cycle count since reset release.
    task automatic test_scan(input int unsigned n);
        int unsigned h, v;
        logic vact, hact, req;
        logic [4:0]  exp_ctl;
        logic [19:0] exp_pix;
        logic [15:0] exp_rgb;
        for (int unsigned i = 0; i < n; i++) begin
            h = t % HT;
            v = (t / HT) % VT;
            vact = (v >= VA) && (v < VA + VV);
            hact = (h >= HA) && (h < HA + HV);
            req  = vact && (h >= HA - 1) && (h < HA + HV - 1);
            exp_ctl = {h < HS, v < VS, vact && hact, h == 0 && v == 0, 1'b1};
            exp_pix = req ? {10'(h - (HA - 1)), 10'(v - VA)} : 20'hFFFFF;
            exp_rgb = (vact && hact) ? {6'(v - VA), 10'(h - HA)} : 16'h0000;
            n_checks++;
            if ({hsync, vsync, tft_de, frame_start, tft_bl} !== exp_ctl) begin
                n_fail++;
                $display("FAIL scan_ctl h=%0d v=%0d: got %b expected %b", h, v,
                         {hsync, vsync, tft_de, frame_start, tft_bl}, exp_ctl);
            end
            n_checks++;
            if ({pix_x, pix_y} !== exp_pix) begin
                n_fail++;
                $display("FAIL scan_pix h=%0d v=%0d: got x=%h y=%h expected x=%h y=%h", h, v,
                         pix_x, pix_y, exp_pix[19:10], exp_pix[9:0]);
            end
            n_checks++;
            if (rgb_tft !== exp_rgb) begin
                n_fail++;
                $display("FAIL scan_rgb h=%0d v=%0d: got %h expected %h", h, v, rgb_tft, exp_rgb);
            end
            step();
        end
    endtask

    task automatic test_mid_reset;
        guard = 0;
        while (((t % HT) != 12 || ((t / HT) % VT) != 7) && guard < LIMIT) step();
        n_checks++;
        if (tft_de !== 1'b1) begin n_fail++; $display("FAIL mid_pre_de: got %b expected 1", tft_de); end
        #1 sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({hsync, vsync, tft_de, tft_bl} !== 4'b1100) begin
            n_fail++;
            $display("FAIL mid_reset_ctl: got %b expected 1100", {hsync, vsync, tft_de, tft_bl});
        end
        n_checks++;
        if ({pix_x, pix_y} !== 20'hFFFFF) begin
            n_fail++;
            $display("FAIL mid_reset_pix: got x=%h y=%h expected 3ff 3ff", pix_x, pix_y);
        end
        n_checks++;
        if (rgb_tft !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_rgb: got %h expected 0000", rgb_tft); end
        repeat (3) @(negedge tft_clk);
        sys_rst_n = 1'b1;
        t = 0;
        test_first_de("after_reset");
    endtask

    initial begin
        test_reset();
        test_first_de("power_on");
        test_line();
        test_frame();
        test_scan(2 * FRAME);
        test_mid_reset();
        test_scan(FRAME);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tft_timing_ctrl.md
# tft_timing_ctrl

Timing generator and pixel sink for the 480x272 RGB565 TFT panel. It runs horizontal and vertical counters on `tft_clk` and drives `hsync`, `vsync` and `tft_de`. It issues pixel coordinates (`pix_x`, `pix_y`) one cycle ahead of display to the upstream pixel generator. The generator registers `pix_data`, so the returned colour is aligned with `tft_de` on the following cycle and passed to the panel as `rgb_tft`.

## Interface
Parameters:
- H_SYNC, 41, hsync pulse width in clocks
- H_BACK, 2, horizontal back porch
- H_VALID, 480, active pixels per line
- H_FRONT, 2, horizontal front porch (H_TOTAL = 525)
- V_SYNC, 10, vsync pulse width in lines
- V_BACK, 2, vertical back porch
- V_VALID, 272, active lines per frame
- V_FRONT, 2, vertical front porch (V_TOTAL = 286)

Ports (reset is `sys_rst_n`, asynchronous, active-low; clock is `tft_clk`):
- tft_clk  in  1  pixel clock
- sys_rst_n  in  1  asynchronous active-low reset
- pix_data  in  16  RGB565 from the pixel generator, registered there, valid one cycle after request
- pix_x  out  10  requested column 0..H_VALID-1; 10'h3FF when no request
- pix_y  out  10  requested row 0..V_VALID-1; 10'h3FF when no request
- rgb_tft  out  16  panel pixel data
- hsync  out  1  horizontal sync, active high
- vsync  out  1  vertical sync, active high
- tft_de  out  1  data enable
- tft_bl  out  1  backlight enable, equal to sys_rst_n
- frame_start  out  1  one-cycle pulse at cnt_h==0 && cnt_v==0

## Operation
Counters:
- cnt_h: 10-bit register, 0..H_TOTAL-1, wraps to 0.
- cnt_v: 10-bit register, increments only when cnt_h==H_TOTAL-1, wraps to 0 after V_TOTAL-1.
- Both are cleared asynchronously by reset.

Window constants:
- HA = H_SYNC+H_BACK = 43.
- VA = V_SYNC+V_BACK = 12.

Output decoding (combinational from the counter registers, except `rgb_tft` as noted):
- hsync = (cnt_h < H_SYNC).
- vsync = (cnt_v < V_SYNC).
- vact = (VA <= cnt_v < VA+V_VALID).
- tft_de = vact && (HA <= cnt_h < HA+H_VALID).
- pix_req = vact && (HA-1 <= cnt_h < HA+H_VALID-1).
- pix_x = pix_req ? cnt_h-(HA-1) : 10'h3FF.
- pix_y = pix_req ? cnt_v-VA : 10'h3FF.
- rgb_tft = tft_de ? pix_data : 16'h0000. This is combinational gating; `pix_data` is already registered upstream.
- frame_start = (cnt_h==0 && cnt_v==0).

Arithmetic and boundaries:
- All comparisons are unsigned 10-bit; parameters are constrained so H_TOTAL, V_TOTAL ≤ 1023.
- pix_x wraps from 479 to 3FF at cnt_h=522. There is no request in porch or sync.
- Row transition: pix_y is 3FF for cnt_v in 0..11 and 284..285, and 0..271 for cnt_v 12..283.
- Frame wrap (cnt_h=524, cnt_v=285): both counters go to 0 on the next edge; frame_start pulses in that cycle.
- Reset mid-frame: counters return to 0 immediately and asynchronously. Outputs take their reset values and the next frame begins at cnt 0 after release; a partial frame is allowed.

## Timing
Reset values of outputs:
- hsync=1, vsync=1, tft_de=0
- pix_x=3FF, pix_y=3FF
- rgb_tft=0
- frame_start=1 (counters at 0)
- tft_bl=0

Latency:
- Request to display is exactly one cycle: pix_x=N at cycle t, then tft_de=1 and rgb_tft=pixel N at t+1.

Counts:
- Line = 525 clocks.
- Frame = 525×286 = 150150 clocks.
- hsync high 41 clocks per line; vsync high 10 lines (5250 clocks) per frame.
- tft_de high 480 consecutive clocks on each of 272 lines.

## Test plan
- Reset release, count cycles: first tft_de=1 at cycle 12×525+43 = 6343. pix_x=0, pix_y=0 at cycle 6342.
- Stub generator returning registered {pix_y[5:0],pix_x[9:0]}: every tft_de cycle rgb_tft equals the expected {row,col}, with no off-by-one. Column 479 is shown at cnt_h=522.
- Line check: hsync high for exactly 41 clocks, period 525; tft_de low for 45 clocks between active runs; pix_x=3FF at cnt_h=522..524 and 0..41.
- Frame check: vsync high 5250 clocks, period 150150; frame_start single-cycle pulse every 150150 clocks; pix_y=271 last, then 3FF for 2 front-porch lines.
- Reset asserted at cnt_v=100, cnt_h=200: outputs immediately hsync=1, vsync=1, de=0, rgb_tft=0, pix_x=3FF, tft_bl=0. After release, first de again 6343 cycles later.
- Generator drives nonzero pix_data during porch: rgb_tft stays 0 whenever tft_de=0.
